// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// LOAD_STORE_FNS
// Shared types and helpers for the load/store unit:
//   funct3_t     - RISC-V load/store funct3 encodings
//   lsu_state_t  - load/store sequencer states
//   byte_ofs / half_ofs - bit offset of the addressed byte / halfword lane
//   is_reserved  - funct3 not legal for the given direction
//   is_misaligned- low address bits violate natural alignment
// -----------------------------------------------------------------------------
package LOAD_STORE_FNS;

    typedef enum logic [2:0] {
        BYTE   = 3'b000,
        HALF   = 3'b001,
        WORD   = 3'b010,
        BYTE_U = 3'b100,
        HALF_U = 3'b101
    } funct3_t;

    typedef enum logic [2:0] {
        IDLE,
        LD_RD,
        LD_CAP,
        ST_WR,
        RMW_RD,
        RMW_MRG,
        RMW_WR,
        RESP
    } lsu_state_t;

    function automatic logic [4:0] byte_ofs(input logic [1:0] lane);
        return {lane, 3'b000};
    endfunction

    // Only the upper lane bit selects a halfword; bit 0 is ignored here.
    function automatic logic [4:0] half_ofs(input logic hi);
        return {hi, 4'b0000};
    endfunction

    // Unsigned variants exist only for loads.
    function automatic logic is_reserved(input logic [2:0] f3, input logic wr);
        case (f3)
            3'b000, 3'b001, 3'b010: return 1'b0;
            3'b100, 3'b101:         return wr;
            default:                return 1'b1;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            3'b001, 3'b101: return lo[0];
            3'b010:         return lo != 2'b00;
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_lane_extract.sv
// -----------------------------------------------------------------------------
// lane_extract
// Combinational lane select plus sign/zero extension of a memory read word.
//   word   - full word read from memory
//   funct3 - load type (BYTE/HALF sign-extend, *_U zero-extend, WORD passthrough)
//   lane   - byte address bits [1:0]
//   result - right-aligned, extended load value
// -----------------------------------------------------------------------------
module lane_extract
    import LOAD_STORE_FNS::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] word,
    input  funct3_t          funct3,
    input  logic [1:0]       lane,
    output logic [WIDTH-1:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[byte_ofs(lane) +: 8];
        half_v = word[half_ofs(lane[1]) +: 16];
        case (funct3)
            BYTE:    result = {{(WIDTH-8){byte_v[7]}}, byte_v};
            BYTE_U:  result = {{(WIDTH-8){1'b0}}, byte_v};
            HALF:    result = {{(WIDTH-16){half_v[15]}}, half_v};
            HALF_U:  result = {{(WIDTH-16){1'b0}}, half_v};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Data-memory initiator: one load/store at a time, byte/half/word addressing,
// word-granular memory cycles. Sub-word stores are read-modify-write because
// the memory has no byte enables.
//
// Ports:
//   clk, rst              - clock, asynchronous active-low reset
//   req_valid/req_ready   - request handshake (ready only when idle)
//   req_wr, req_addr, req_wdata, req_funct3 - request fields
//   resp_valid            - one-cycle completion pulse
//   resp_rdata, resp_err  - load result / rejection flag, held until next response
//   mem_addr, mem_wren, mem_wr_data, mem_funct3 - word memory request
//   mem_rd_data           - read word, valid the cycle after mem_addr is sampled
//
// Build option: LSU_ALIGN_CHECK_EN - reject misaligned half/word accesses
// instead of silently clearing the offending low address bits.
// -----------------------------------------------------------------------------
module load_store_unit
    import LOAD_STORE_FNS::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  funct3_t          req_funct3,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_wren,
    output logic [WIDTH-1:0] mem_wr_data,
    output funct3_t          mem_funct3,
    input  logic [WIDTH-1:0] mem_rd_data
);

    lsu_state_t       state;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    funct3_t          funct3_q;
    logic             wr_q;
    logic [WIDTH-1:0] merged_q;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] load_data;
    logic             req_err;

`ifdef LSU_ALIGN_CHECK_EN
    assign req_err = is_reserved(req_funct3, req_wr) ||
                     is_misaligned(req_funct3, req_addr[1:0]);
`else
    // Misaligned accesses proceed with the low bits dropped.
    assign req_err = is_reserved(req_funct3, req_wr);
`endif

    assign req_ready   = (state == IDLE);
    assign mem_addr    = {addr_q[WIDTH-1:2], 2'b00};
    assign mem_funct3  = WORD;
    // Word stores write the latched data directly; sub-word stores the merge.
    assign mem_wr_data = (state == RMW_WR) ? merged_q : wdata_q;

    lane_extract #(.WIDTH(WIDTH)) u_lane_extract (
        .word   (mem_rd_data),
        .funct3 (funct3_q),
        .lane   (addr_q[1:0]),
        .result (load_data)
    );

    // Overlay the store lane on the word read back (only SB/SH reach RMW).
    always_comb begin
        merged = mem_rd_data;
        if (funct3_q == HALF)
            merged[half_ofs(addr_q[1]) +: 16] = wdata_q[15:0];
        else
            merged[byte_ofs(addr_q[1:0]) +: 8] = wdata_q[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            funct3_q   <= BYTE;
            wr_q       <= 1'b0;
            merged_q   <= '0;
            mem_wren   <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            mem_wren   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        funct3_q <= req_funct3;
                        wr_q     <= req_wr;
                        if (req_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (!req_wr) begin
                            state <= LD_RD;
                        end else if (req_funct3 == WORD) begin
                            state    <= ST_WR;
                            mem_wren <= 1'b1;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                LD_RD:   state <= LD_CAP;
                RMW_RD:  state <= RMW_MRG;
                RMW_MRG: begin
                    merged_q <= merged;
                    mem_wren <= 1'b1;
                    state    <= RMW_WR;
                end
                // All successful paths funnel through here into RESP.
                LD_CAP, ST_WR, RMW_WR: begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= wr_q ? '0 : load_data;
                    state      <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory interface. Sits between the core's execute stage and the `memory` block: accepts one load/store request at a time, handles RISC-V byte/halfword/word addressing, and drives word-granular memory cycles. Loads extract and sign-/zero-extend the addressed lane. The memory has no byte enables, so sub-word stores are done as read-modify-write.

## Interface
- `WIDTH`, 32, data/address width; byte lanes = WIDTH/8 = 4
- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `req_valid` in 1: request present; held stable by requester until accepted
- `req_ready` out 1: high only in IDLE; accept = `req_valid && req_ready` at a rising edge
- `req_wr` in 1: 0 = load, 1 = store
- `req_addr` in WIDTH: byte address
- `req_wdata` in WIDTH: store data, right-aligned
- `req_funct3` in `funct3_t`: RISC-V funct3 (LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101)
- `resp_valid` out 1: one-cycle completion pulse; no backpressure
- `resp_rdata` out WIDTH: load result; 0 for stores and errors
- `resp_err` out 1: request rejected (reserved funct3 or misaligned); qualified by `resp_valid`
- `mem_addr` out WIDTH: byte address to memory, bits [1:0] forced to 0
- `mem_wren` out 1: memory write strobe
- `mem_wr_data` out WIDTH: full word to write
- `mem_funct3` out `funct3_t`: constant WORD
- `mem_rd_data` in WIDTH: memory read word; valid the cycle after `mem_addr` is sampled

## Operation
- Accepted request fields are latched into `addr_q`, `wdata_q`, `funct3_q`, `wr_q`. Memory outputs are driven from these latched registers only.
- FSM states: IDLE, LD_RD, LD_CAP, ST_WR, RMW_RD, RMW_MRG, RMW_WR, RESP.
- IDLE → on accept:
  - Reserved funct3 (011, 110, 111; or stores with 100/101) → RESP with err.
  - Misaligned request → RESP with err.
  - Load → LD_RD.
  - SW → ST_WR.
  - SB/SH → RMW_RD.
- LD_RD: present `mem_addr`, `mem_wren`=0 → LD_CAP.
- LD_CAP: select lane `b = addr_q[1:0]` and register the result → RESP.
  - LB: byte `mem_rd_data[8b+:8]`, sign-extended.
  - LBU: same byte, zero-extended.
  - LH/LHU: half `mem_rd_data[16*addr_q[1]+:16]`, sign-/zero-extended.
  - LW: whole word.
- ST_WR: `mem_wren`=1, `mem_wr_data`=`wdata_q` → RESP.
- RMW_RD: read as LD_RD → RMW_MRG.
- RMW_MRG: replace the addressed lane of `mem_rd_data` with `wdata_q[7:0]` (SB) or `wdata_q[15:0]` (SH); register the merged word → RMW_WR.
- RMW_WR: `mem_wren`=1 for exactly one cycle → RESP.
- RESP: `resp_valid`=1 for one cycle → IDLE.
  - `resp_rdata`/`resp_err` are held until the next response.
- Exactly one memory write per store; zero writes for loads and errors.

## Timing
- Accept edge E0. Cycles are numbered after E0.
- Word store: `mem_wren` high in cycle 1; `resp_valid` in cycle 2.
- Load: `mem_addr` in cycle 1; data captured in cycle 2; `resp_valid` in cycle 3.
- Sub-word store: read in cycle 1; merge in cycle 2; `mem_wren` in cycle 3; `resp_valid` in cycle 4.
- Error: `resp_valid`+`resp_err` in cycle 1; no memory cycle.
- `req_ready` is low from cycle 1 until RESP completes. It returns high the cycle after `resp_valid`, so back-to-back throughput is latency+1 cycles.
- `req_valid` while busy is ignored.
- Reset values:
  - state IDLE, so `req_ready`=1
  - `resp_valid`, `resp_err`, `resp_rdata`, `mem_wren`, `mem_addr`, `mem_wr_data` all 0
- Reset mid-operation: state returns to IDLE immediately; `mem_wren` drops asynchronously; the pending access is dropped with no response.
  - Reset during RMW_RD/RMW_MRG leaves the memory word unmodified.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - LH/LHU/SH with `addr[0]`=1 → error.
  - LW/SW with `addr[1:0]`≠0 → error.
- Not defined:
  - Offending low address bits are ignored (half: bit 0 treated as 0; word: bits [1:0] treated as 0), and the access proceeds.
  - `resp_err` asserts only for reserved funct3.

## Structure
- `LOAD_STORE_FNS` package owns:
  - `funct3_t` enum (BYTE, HALF, WORD, BYTE_U, HALF_U)
  - `lsu_state_t`
  - lane-select helpers
- One sub-module, `lane_extract`: combinational byte/half select plus sign/zero extension, used in LD_CAP.
- Merge logic stays inline.

## Test plan
- SW 0x10 data 0xDEADBEEF:
  - `mem_wren` in cycle 1 at 0x10; `resp_valid` in cycle 2.
  - A following LW 0x10 returns 0xDEADBEEF in cycle 3.
- Word 0x20 = 0x80FF7F01:
  - LB 0x21 → 0x0000007F
  - LB 0x22 → 0xFFFFFFFF
  - LBU 0x23 → 0x00000080
  - LH 0x22 → 0xFFFF80FF
  - LHU 0x20 → 0x00007F01
- Word 0x30 = 0x11223344:
  - SB 0x31 data 0x123456AB → word becomes 0x1122AB44.
  - Then SH 0x32 data 0x0000CAFE → word becomes 0xCAFEAB44.
  - Exactly one `mem_wren` pulse per store; `resp_valid` in cycle 4.
- LW 0x42:
  - With macro: `resp_err`=1 in cycle 1, `resp_rdata`=0, no memory access.
  - Without macro: returns word at 0x40.
  - funct3=011 → `resp_err`=1 in both builds.
- Reset deasserted→asserted during RMW_MRG of SB 0x31:
  - no `mem_wren`; word unchanged; no `resp_valid`.
  - `req_ready`=1 immediately.
- Two requests with `req_valid` held continuously:
  - Second accepted on the edge after the first's `resp_valid`.
  - No request lost or duplicated.
